aes128_decrypt: RTL



---
 rtl/aes128_pkg.sv | 96 +++++++++
 rtl/aes128_inv_round.sv | 26 ++
 rtl/aes128_decrypt.sv | 112 +++++++++++
 3 files changed

// File: rtl/aes128_pkg.sv
// aes128_pkg: shared AES-128 constants, GF(2^8) helpers and the decryptor FSM state type
// Contents: SBOX/INV_SBOX byte tables, RCON round constants, xtime, gf_mul,
//           inv_shift_rows, inv_mix_columns, sub_word, dec_state_e.
// Byte i of a 128-bit block sits in bits [127-8i -: 8]; byte index = row + 4*column.
package aes128_pkg;

    typedef enum logic [2:0] {IDLE, KEYEXP, ADDKEY, ROUND, FINAL} dec_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Entry 0 is unused; lets the key-expansion counter index the table directly.
    localparam logic [7:0] RCON [11] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // InvMixColumns row coefficients, rotated right by one per output row.
    localparam logic [7:0] IMC [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [1:0]   idx;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < 4; k++) begin
                    idx = 2'(k - r);
                    o[127-8*(4*c+r) -: 8] ^= gf_mul(IMC[idx], s[127-8*(4*c+k) -: 8]);
                end
        return o;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes128_inv_round.sv
// aes128_inv_round: combinational AES inverse round shared by the ROUND and FINAL steps
// Ports: state_i  - current cipher state
//        rkey_i   - round key to add
//        skip_mix_i - bypass InvMixColumns (final round)
//        state_o  - next cipher state
module aes128_inv_round
    import aes128_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         skip_mix_i,
    output logic [127:0] state_o
);

    logic [127:0] shifted, subbed, keyed;

    assign shifted = inv_shift_rows(state_i);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        assign subbed[8*i +: 8] = INV_SBOX[shifted[8*i +: 8]];
    end

    assign keyed   = subbed ^ rkey_i;
    assign state_o = skip_mix_i ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes128_decrypt.sv
// aes128_decrypt: iterative AES-128 decryptor, on-chip key expansion then one inverse round per clock
// Ports: CLK, RST_N (async active-low)
//        decEnable     - start request, sampled only while idle
//        dataToOperate - ciphertext, keyToOperate - cipher key
//        opBusy        - operation in progress
//        opComplete    - one-cycle result-valid pulse
//        opRetValue    - plaintext, held until the next completion
module aes128_decrypt
    import aes128_pkg::*;
(
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         decEnable,
    input  logic [127:0] dataToOperate,
    input  logic [127:0] keyToOperate,
    output logic         opBusy,
    output logic         opComplete,
    output logic [127:0] opRetValue
);

    dec_state_e          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [127:0]        data_q, data_d, ret_q, ret_d;
    logic [10:0][127:0]  rk_q, rk_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [127:0]        prev_key, next_key, round_out;
    logic [31:0]         w0, w1, w2, w3;

    // One key-schedule step: round key cnt from round key cnt-1.
    assign prev_key = rk_q[cnt_q - 4'd1];
    assign w0 = prev_key[127:96] ^ sub_word({prev_key[23:0], prev_key[31:24]}) ^ {RCON[cnt_q], 24'h0};
    assign w1 = prev_key[95:64] ^ w0;
    assign w2 = prev_key[63:32] ^ w1;
    assign w3 = prev_key[31:0]  ^ w2;
    assign next_key = {w0, w1, w2, w3};

    // cnt selects the active round key in every state: 10 in ADDKEY, 9..1 in ROUND, 0 in FINAL.
    aes128_inv_round u_round (
        .state_i   (data_q),
        .rkey_i    (rk_q[cnt_q]),
        .skip_mix_i(state_q == FINAL),
        .state_o   (round_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rk_d    = rk_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ret_d   = ret_q;
        case (state_q)
            IDLE: if (decEnable) begin
                data_d  = dataToOperate;
                rk_d[0] = keyToOperate;
                cnt_d   = 4'd1;
                busy_d  = 1'b1;
                state_d = KEYEXP;
            end
            // cnt is left at 10 on exit so ADDKEY picks roundKey[10].
            KEYEXP: begin
                rk_d[cnt_q] = next_key;
                cnt_d   = (cnt_q == 4'd10) ? cnt_q : cnt_q + 4'd1;
                state_d = (cnt_q == 4'd10) ? ADDKEY : KEYEXP;
            end
            ADDKEY: begin
                data_d  = data_q ^ rk_q[cnt_q];
                cnt_d   = 4'd9;
                state_d = ROUND;
            end
            ROUND: begin
                data_d  = round_out;
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? FINAL : ROUND;
            end
            FINAL: begin
                data_d  = round_out;
                ret_d   = round_out;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            rk_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rk_q    <= rk_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ret_q   <= ret_d;
        end
    end

    assign opBusy     = busy_q;
    assign opComplete = done_q;
    assign opRetValue = ret_q;

endmodule
